// File: rtl/system_pio_key_poller.sv
`default_nettype none
// ============================================================================
// Module      : system_pio_key_poller
// Description : Avalon-MM read master that polls a key PIO data register at a
//               fixed rate, debounces each key, emits press/release pulses and
//               keeps a sticky edge-capture register with a masked interrupt.
//               Keys are active-low (1 = released, 0 = pressed).
// Revision    : 1.0 - initial release
// ============================================================================
module system_pio_key_poller #(
    parameter int WIDTH            = 2,
    parameter int PIO_ADDR         = 0,
    parameter int POLL_CYCLES      = 50000,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_readdatavalid,
    output logic [WIDTH-1:0] key_state,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic [WIDTH-1:0] edge_capture,
    input  logic [WIDTH-1:0] edge_clear,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq,
    output logic             poll_error
);

    localparam int TMR_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_SAMPLES + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_SAMPLES - 1);
    localparam logic [1:0]       ADDR     = 2'(PIO_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [WIDTH-1:0]  sample_q, sample_d;
    logic              read_q, read_d;
    logic [WIDTH-1:0]  key_state_q, key_state_d;
    logic [WIDTH-1:0]  key_press_q, key_press_d;
    logic [WIDTH-1:0]  key_release_q, key_release_d;
    logic [WIDTH-1:0]  edge_capture_q, edge_capture_d;
    logic              irq_q, irq_d;
    logic              poll_error_q, poll_error_d;

    logic              w_tick;
    logic              w_update;
    logic [WIDTH-1:0]  w_flip;
    logic              w_unused_readdata;

    assign w_tick            = (timer_q == TMR_LAST);
    assign w_update          = (state_q == ST_UPDATE);
    // Only the low WIDTH bits of the PIO data word carry key levels
    assign w_unused_readdata = ^avm_readdata;

    // Per-key debounce: count consecutive samples disagreeing with the level
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            differ;
        logic            flip;

        // Next counter value and toggle decision, evaluated only in UPDATE
        always_comb begin
            cnt_d  = cnt_q;
            differ = sample_q[gi] ^ key_state_q[gi];
            flip   = 1'b0;
            if (w_update) begin
                if (!differ) begin
                    cnt_d = '0;
                end else if (cnt_q >= DB_LAST) begin
                    // Reaching the threshold toggles the level; >= also saturates
                    flip  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        assign w_flip[gi] = flip;

        // Debounce counter register
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Poll timer, bus FSM, key outputs, edge capture and interrupt next-state
    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        sample_d     = sample_q;
        poll_error_d = poll_error_q;
        timer_d      = w_tick ? '0 : timer_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (w_tick) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (!avm_waitrequest) begin
                    state_d  = ST_WAIT;
                    to_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (avm_readdatavalid) begin
                    sample_d = avm_readdata[WIDTH-1:0];
                    state_d  = ST_UPDATE;
                end else if (to_cnt_q + 1'b1 == TO_LIMIT) begin
                    poll_error_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A tick while a poll is still in flight is dropped and flagged
        if (w_tick && (state_q != ST_IDLE)) begin
            poll_error_d = 1'b1;
        end

        read_d         = (state_d == ST_READ);
        key_state_d    = key_state_q ^ w_flip;
        key_press_d    = key_state_q & w_flip;
        key_release_d  = ~key_state_q & w_flip;
        // Set has priority over write-one-to-clear
        edge_capture_d = (edge_capture_q & ~edge_clear) | key_press_q;
        irq_d          = |(edge_capture_q & irq_mask);
    end

    // Single register stage for the FSM and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            to_cnt_q       <= '0;
            sample_q       <= '1;
            read_q         <= 1'b0;
            key_state_q    <= '1;
            key_press_q    <= '0;
            key_release_q  <= '0;
            edge_capture_q <= '0;
            irq_q          <= 1'b0;
            poll_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            to_cnt_q       <= to_cnt_d;
            sample_q       <= sample_d;
            read_q         <= read_d;
            key_state_q    <= key_state_d;
            key_press_q    <= key_press_d;
            key_release_q  <= key_release_d;
            edge_capture_q <= edge_capture_d;
            irq_q          <= irq_d;
            poll_error_q   <= poll_error_d;
        end
    end

    assign avm_address  = ADDR;
    assign avm_read     = read_q;
    assign key_state    = key_state_q;
    assign key_press    = key_press_q;
    assign key_release  = key_release_q;
    assign edge_capture = edge_capture_q;
    assign irq          = irq_q;
    assign poll_error   = poll_error_q;

endmodule
`default_nettype wire

// File: tb/tb_system_pio_key_poller.sv
`default_nettype none
// ============================================================================
// Module      : tb_system_pio_key_poller
// Description : Self-checking bench for system_pio_key_poller. Acts as the PIO
//               responder and keeps a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_system_pio_key_poller;

    localparam int W  = 2;
    localparam int PC = 8;
    localparam int DB = 3;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   avm_address;
    logic         avm_read;
    logic         avm_waitrequest = 1'b0;
    logic [31:0]  avm_readdata = '0;
    logic         avm_readdatavalid = 1'b0;
    logic [W-1:0] key_state, key_press, key_release, edge_capture;
    logic [W-1:0] edge_clear = '0;
    logic [W-1:0] irq_mask = '0;
    logic         irq, poll_error;

    system_pio_key_poller #(
        .WIDTH(W), .PIO_ADDR(0), .POLL_CYCLES(PC),
        .DEBOUNCE_SAMPLES(DB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .key_state(key_state), .key_press(key_press), .key_release(key_release),
        .edge_capture(edge_capture), .edge_clear(edge_clear), .irq_mask(irq_mask),
        .irq(irq), .poll_error(poll_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int k = 0;

    // Model expectations for the current cycle
    logic         cmp_en = 1'b0;
    logic         exp_read = 1'b0;
    logic [W-1:0] exp_ks = '1, exp_press = '0, exp_rel = '0, exp_ec = '0;
    logic         exp_irq = 1'b0, exp_err = 1'b0;
    logic [W-1:0] nxt_ec = '0;
    logic         nxt_irq = 1'b0;
    int           run [W];

    // Transaction schedule (cycle numbers)
    int free_at = 0, rd_start = 1, acc = 0, valid_at = -1;
    int wlo = -1, whi = -2, apply_at = -1, late_at = -1;
    int err_time = 32'h7fff_ffff;
    int planned = 0;
    logic [W-1:0] pend = '1;
    logic [W-1:0] held = '1;

    // Knobs
    int  knob_w = -1;
    bit  knob_to = 0, knob_late = 0, rand_en = 0, ph6 = 0;
    int  mark = -100;
    logic [W-1:0] samp_q [$];

    // Observed statistics
    int rd_cycles = 0, acc_cnt = 0, press_cnt = 0, rel_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, k);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("avm_read", avm_read, exp_read);
            check("avm_address", avm_address, 2'b00);
            check("key_state", key_state, exp_ks);
            check("key_press", key_press, exp_press);
            check("key_release", key_release, exp_rel);
            check("edge_capture", edge_capture, exp_ec);
            check("irq", irq, exp_irq);
            check("poll_error", poll_error, exp_err);
        end
    end

    task automatic zero_stats();
        rd_cycles = 0; acc_cnt = 0; press_cnt = 0; rel_cnt = 0;
    endtask

    // One clock cycle: model expectations, responder drive, advance
    task automatic step();
        int w, lat;
        bit to;
        exp_read  = (k >= rd_start) && (k <= acc);
        exp_press = '0;
        exp_rel   = '0;
        if (k == apply_at) begin
            for (int i = 0; i < W; i++) begin
                if (pend[i] == exp_ks[i]) begin
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] == DB) begin
                        run[i] = 0;
                        exp_ks[i] = ~exp_ks[i];
                        if (exp_ks[i]) exp_rel[i] = 1'b1;
                        else           exp_press[i] = 1'b1;
                    end
                end
            end
        end
        exp_err = (k >= err_time);
        exp_ec  = nxt_ec;
        exp_irq = nxt_irq;

        if (k % PC == PC - 1) begin
            if (k < free_at) begin
                if (err_time > k + 1) err_time = k + 1;
            end else begin
                w = (knob_w >= 0) ? knob_w : (rand_en ? int'($urandom_range(0, 2)) : 0);
                knob_w = -1;
                to = knob_to || (rand_en && ($urandom_range(0, 9) == 0));
                knob_to = 0;
                lat = rand_en ? int'($urandom_range(1, 3)) : 1;
                rd_start = k + 1;
                acc = k + 1 + w;
                wlo = acc + 1;
                if (to) begin
                    whi = acc + TO;
                    valid_at = -1;
                    free_at = acc + TO + 1;
                    if (err_time > free_at) err_time = free_at;
                    late_at = knob_late ? free_at : -1;
                    knob_late = 0;
                end else begin
                    whi = acc + lat;
                    valid_at = acc + lat;
                    apply_at = acc + lat + 2;
                    free_at = apply_at;
                    if (samp_q.size() > 0) begin
                        pend = samp_q.pop_front();
                    end else if (rand_en) begin
                        if ($urandom_range(0, 7) == 0) held = 2'($urandom);
                        pend = held ^ (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
                    end else begin
                        pend = 2'b11;
                    end
                end
                planned++;
            end
        end

        if (k >= rd_start && k < acc)  avm_waitrequest = 1'b1;
        else if (k == acc)             avm_waitrequest = 1'b0;
        else                           avm_waitrequest = rand_en ? 1'($urandom) : 1'b0;

        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
        if (k == valid_at) begin
            avm_readdatavalid = 1'b1;
            avm_readdata[1:0] = pend;
        end else if (k == late_at) begin
            avm_readdatavalid = 1'b1;
            avm_readdata[1:0] = 2'b00;
        end else if (rand_en && !(k >= wlo && k <= whi) && ($urandom_range(0, 5) == 0)) begin
            avm_readdatavalid = 1'b1;
        end

        if (ph6) begin
            edge_clear = '0;
            if (exp_press != '0 && mark < 0) begin
                mark = k;
                edge_clear = 2'b01;
            end else if (k == mark + 1) begin
                edge_clear = 2'b01;
            end
        end else if (rand_en) begin
            edge_clear = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            irq_mask = 2'($urandom);
        end

        if (k == mark + 1) check("p6_same_cycle_set_wins", edge_capture, 2'b01);
        if (k == mark + 2) check("p6_clear_next_cycle", edge_capture, 2'b00);
        if (k == mark + 3) check("p6_irq_dropped", irq, 1'b0);

        nxt_ec  = (exp_ec & ~edge_clear) | exp_press;
        nxt_irq = |(exp_ec & irq_mask);

        rd_cycles += int'(avm_read);
        acc_cnt   += int'(avm_read && !avm_waitrequest);
        press_cnt += int'(key_press != '0);
        rel_cnt   += int'(key_release != '0);

        @(posedge clk);
        #1;
        k++;
    endtask

    // Run until n more polls have been issued and the last one has settled
    task automatic run_polls(input int n);
        int target;
        int budget;
        target = planned + n;
        budget = 0;
        while ((planned < target || k <= free_at + 1) && budget < 2000) begin
            step();
            budget++;
        end
        if (budget >= 2000) begin
            checks++;
            failures++;
            $display("FAIL run_polls_bound: polls issued %0d required %0d", planned, target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < W; i++) run[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;

        check("rst_avm_read", avm_read, 1'b0);
        check("rst_avm_address", avm_address, 2'b00);
        check("rst_key_state", key_state, 2'b11);
        check("rst_key_press", key_press, 2'b00);
        check("rst_key_release", key_release, 2'b00);
        check("rst_edge_capture", edge_capture, 2'b00);
        check("rst_irq", irq, 1'b0);
        check("rst_poll_error", poll_error, 1'b0);
        cmp_en = 1'b1;

        // Idle polling with released keys
        zero_stats();
        run_polls(3);
        check("p1_read_cycles", rd_cycles, 3);
        check("p1_accepts", acc_cnt, 3);
        check("p1_key_state", key_state, 2'b11);
        check("p1_pulses", press_cnt + rel_cnt, 0);
        check("p1_edge_capture", edge_capture, 2'b00);

        // Press key 0, then release it
        irq_mask = 2'b01;
        zero_stats();
        samp_q = '{2'b10, 2'b10, 2'b10};
        run_polls(3);
        check("p2_key_state", key_state, 2'b10);
        check("p2_press_cycles", press_cnt, 1);
        check("p2_edge_capture", edge_capture, 2'b01);
        check("p2_irq", irq, 1'b1);
        zero_stats();
        samp_q = '{2'b11, 2'b11, 2'b11};
        run_polls(3);
        check("p2_release_state", key_state, 2'b11);
        check("p2_release_cycles", rel_cnt, 1);
        check("p2_edge_sticky", edge_capture, 2'b01);

        // Bounce never reaches the threshold
        zero_stats();
        samp_q = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
        run_polls(5);
        check("p3_key_state", key_state, 2'b11);
        check("p3_pulses", press_cnt + rel_cnt, 0);
        check("p3_poll_error", poll_error, 1'b0);

        // Stalled read overlapping the next tick
        zero_stats();
        knob_w = 5;
        run_polls(1);
        check("p4_read_cycles", rd_cycles, 6);
        check("p4_accepts", acc_cnt, 1);
        check("p4_poll_error", poll_error, 1'b1);

        // Timeout followed by late data, then a normal poll
        samp_q = '{2'b00, 2'b00};
        run_polls(2);
        zero_stats();
        knob_to = 1;
        knob_late = 1;
        run_polls(1);
        check("p5_key_state_after_late", key_state, 2'b11);
        samp_q = '{2'b11};
        run_polls(1);
        check("p5_accepts", acc_cnt, 2);
        check("p5_key_state", key_state, 2'b11);

        // Edge clear colliding with a press
        edge_clear = 2'b11;
        step();
        edge_clear = 2'b00;
        ph6 = 1;
        samp_q = '{2'b10, 2'b10, 2'b10};
        run_polls(3);
        ph6 = 0;
        check("p6_key_state", key_state, 2'b10);

        // Randomized traffic
        rand_en = 1;
        run_polls(60);
        rand_en = 0;
        edge_clear = '0;

        // Reset in the middle of a stalled read
        knob_w = 4;
        n = 0;
        while (!exp_read && n < 40) begin
            step();
            n++;
        end
        check("rr_read_before_reset", avm_read, 1'b1);
        cmp_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rr_avm_read", avm_read, 1'b0);
        check("rr_key_state", key_state, 2'b11);
        check("rr_edge_capture", edge_capture, 2'b00);
        check("rr_poll_error", poll_error, 1'b0);
        check("rr_key_press", key_press, 2'b00);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/system_pio_key_poller.md
Name: system_pio_key_poller

Overview:
Avalon-MM read master that polls the key PIO data register (register 0, returns in_port in readdata[1:0]) at a fixed rate. It debounces each key, produces one-cycle press and release pulses, and holds a sticky edge-capture register with a masked interrupt output. It sits between the key PIO slave and user logic, so that user logic never needs a CPU to service the keys. Keys are active-low: 1 = released, 0 = pressed.

Parameters:
WIDTH, 2, number of key bits used from readdata[WIDTH-1:0]
PIO_ADDR, 0, register word address driven on avm_address
POLL_CYCLES, 50000, clk cycles between poll ticks (1 ms at 50 MHz); must be >= 4
DEBOUNCE_SAMPLES, 4, consecutive differing samples required to flip a key state; must be >= 1
TIMEOUT_CYCLES, 64, maximum cycles to wait for readdatavalid after the read is accepted

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
avm_address  out  2  Avalon-MM word address; constant PIO_ADDR
avm_read  out  1  Avalon-MM read request
avm_waitrequest  in  1  slave stall; the read is accepted on a cycle with avm_read=1 and avm_waitrequest=0
avm_readdata  in  32  read data; only bits [WIDTH-1:0] are used
avm_readdatavalid  in  1  qualifies avm_readdata
key_state  out  WIDTH  debounced key level
key_press  out  WIDTH  one-cycle pulse when a key_state bit goes 1->0
key_release  out  WIDTH  one-cycle pulse when a key_state bit goes 0->1
edge_capture  out  WIDTH  sticky press flags
edge_clear  in  WIDTH  write-one-to-clear for edge_capture; level-sampled each cycle
irq_mask  in  WIDTH  interrupt enable per bit
irq  out  1  OR of (edge_capture AND irq_mask)
poll_error  out  1  sticky; set on timeout or tick overrun; cleared only by reset

Behaviour:
- Reset values: avm_read=0, avm_address=PIO_ADDR, key_state=all ones, key_press=0, key_release=0, edge_capture=0, poll_error=0, irq=0. The poll timer, debounce counters and timeout counter reset to 0, and the FSM resets to IDLE.
- Poll timer runs freely from 0 to POLL_CYCLES-1, then wraps to 0. The cycle in which the timer equals POLL_CYCLES-1 is a tick.
- FSM states:
  - IDLE: on a tick, go to READ.
  - READ: avm_read=1; hold avm_read and avm_address stable while avm_waitrequest=1; when avm_waitrequest=0, go to WAIT with the timeout counter cleared.
  - WAIT: avm_read=0; the timeout counter increments each cycle. On avm_readdatavalid, latch avm_readdata[WIDTH-1:0] as the sample and go to UPDATE. If the count reaches TIMEOUT_CYCLES with no valid, set poll_error and go to IDLE; no sample is taken.
  - UPDATE: single cycle that applies the debounce step, then goes to IDLE.
- readdatavalid arriving in IDLE, READ or UPDATE is ignored. This covers late data after a timeout and data after reset.
- Tick outside IDLE: the tick is dropped and poll_error is set. There is no queuing.
- Debounce, per bit i, in UPDATE only:
  - If the sample equals key_state[i], the counter is cleared.
  - Otherwise the counter increments. When the incremented value equals DEBOUNCE_SAMPLES, key_state[i] toggles and the counter is cleared.
  - The counter saturates and cannot wrap.
- key_press and key_release are registered and high for exactly the one cycle after UPDATE, i.e. in the same cycle that the new key_state is first visible. Otherwise they are 0.
- edge_capture[i] is set by key_press[i] and cleared by edge_clear[i]. If both occur in the same cycle, set wins.
- irq is registered from edge_capture & irq_mask, so it lags edge_capture by 1 cycle.
- Reset asserted mid-transaction: avm_read drops in the cycle after the reset edge and every state returns to its reset value. The slave must tolerate an abandoned read, which the PIO does.
- Latency from a tick to a key_press pulse is 3 + waitrequest cycles + read latency.

Test Plan:
Bench overrides: POLL_CYCLES=8, DEBOUNCE_SAMPLES=3, TIMEOUT_CYCLES=16, WIDTH=2. The bench responder has 0 waitrequest and readdatavalid 1 cycle after acceptance unless stated otherwise.
1. Release reset and return 2'b11 on every read -> avm_read pulses high for 1 cycle every 8 cycles, key_state=11, key_press/key_release/edge_capture/poll_error stay 0.
2. Return 10,10,10, with irq_mask=01 -> after the 3rd UPDATE key_state=10, key_press=01 for exactly 1 cycle, edge_capture=01, irq=1 on the next cycle. Return 11 three times -> key_release=01 pulse, edge_capture stays 01.
3. Bounce sequence 10,11,10,10,11 -> key_state stays 11, no pulses.
4. Hold avm_waitrequest=1 for 5 cycles on a read -> avm_read and avm_address=0 stable throughout, exactly one accepted read, and a tick landing in this window sets poll_error.
5. Withhold readdatavalid for 16 cycles -> poll_error=1, FSM back to IDLE, no key_state change. A late readdatavalid with 2'b00 is ignored and the next poll proceeds normally.
6. Assert edge_clear=01 in the same cycle key_press=01 -> edge_capture=01. Assert edge_clear=01 one cycle later -> edge_capture=00, and irq=0 on the following cycle.
